// File: rtl/complex_arith_pipe.sv
// complex_arith_pipe: pipelined complex add/sub/mul/conj-mul with valid/ready.
// Packed words carry the real part in the upper W bits and the imaginary part in the lower W bits.
// Define COMPLEX_SAT_EN to clamp each result component instead of wrapping it modulo 2^W.
module complex_arith_pipe #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           ovf
);

  // Single global advance: every stage moves together, or everything holds.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // ---------------- S1: operand capture ----------------
  logic           r_s1_valid;
  logic [1:0]     r_s1_op;
  logic [2*W-1:0] r_s1_a;
  logic [2*W-1:0] r_s1_b;

  // Capture op and operands on an accepted beat; an empty slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // ---------------- S2: products and sums ----------------
  logic signed [W-1:0]   w_ar, w_ai, w_br, w_bi;
  logic signed [2*W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [W:0]     w_s_re, w_s_im;

  assign w_ar = r_s1_a[2*W-1:W];
  assign w_ai = r_s1_a[W-1:0];
  assign w_br = r_s1_b[2*W-1:W];
  assign w_bi = r_s1_b[W-1:0];

  // Full-precision signed products; operands are sign-extended before multiplying.
  assign w_p_rr = (2*W)'(w_ar) * (2*W)'(w_br);
  assign w_p_ii = (2*W)'(w_ai) * (2*W)'(w_bi);
  assign w_p_ri = (2*W)'(w_ar) * (2*W)'(w_bi);
  assign w_p_ir = (2*W)'(w_ai) * (2*W)'(w_br);

  // op bit 0 selects subtract for the add/sub pair.
  assign w_s_re = r_s1_op[0] ? (W+1)'(w_ar) - (W+1)'(w_br) : (W+1)'(w_ar) + (W+1)'(w_br);
  assign w_s_im = r_s1_op[0] ? (W+1)'(w_ai) - (W+1)'(w_bi) : (W+1)'(w_ai) + (W+1)'(w_bi);

  logic                  r_s2_valid;
  logic [1:0]            r_s2_op;
  logic signed [2*W-1:0] r_s2_p_rr, r_s2_p_ii, r_s2_p_ri, r_s2_p_ir;
  logic signed [W:0]     r_s2_s_re, r_s2_s_im;

  // Register products and sums; both are kept and S3 picks by op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_op   <= r_s1_op;
        r_s2_p_rr <= w_p_rr;
        r_s2_p_ii <= w_p_ii;
        r_s2_p_ri <= w_p_ri;
        r_s2_p_ir <= w_p_ir;
        r_s2_s_re <= w_s_re;
        r_s2_s_im <= w_s_im;
      end
    end
  end

  // ---------------- S3: combine into 2W+1-bit components ----------------
  logic signed [2*W:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [2*W:0] w_c_re, w_c_im;

  assign w_rr = (2*W+1)'(r_s2_p_rr);
  assign w_ii = (2*W+1)'(r_s2_p_ii);
  assign w_ri = (2*W+1)'(r_s2_p_ri);
  assign w_ir = (2*W+1)'(r_s2_p_ir);

  // Select the sum/difference for op 0/1, otherwise combine the cross products.
  always_comb begin
    w_c_re = (2*W+1)'(r_s2_s_re);
    w_c_im = (2*W+1)'(r_s2_s_im);
    case (r_s2_op)
      2'd2: begin
        w_c_re = w_rr - w_ii;
        w_c_im = w_ri + w_ir;
      end
      2'd3: begin
        w_c_re = w_rr + w_ii;
        w_c_im = w_ir - w_ri;
      end
      default: ;
    endcase
  end

  logic                r_s3_valid;
  logic signed [2*W:0] r_s3_res [2];  // [1] = real, [0] = imaginary

  // Register the exact intermediates so the output stage only reduces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_res[1] <= w_c_re;
        r_s3_res[0] <= w_c_im;
      end
    end
  end

  // ---------------- Output: range reduction and overflow ----------------
  logic [W-1:0] w_res [2];
  logic [1:0]   w_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      // A component fits in W signed bits exactly when bits [2W:W-1] are all equal.
      logic [W+1:0] w_top;
      assign w_top     = r_s3_res[gi][2*W:W-1];
      assign w_ovf[gi] = !((&w_top) || !(|w_top));
`ifdef COMPLEX_SAT_EN
      assign w_res[gi] = !w_ovf[gi] ? r_s3_res[gi][W-1:0] :
                         (w_top[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
      assign w_res[gi] = r_s3_res[gi][W-1:0];
`endif
    end
  endgenerate

  // Output register: loads on advance, holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        out <= {w_res[1], w_res[0]};
        ovf <= |w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_complex_arith_pipe.sv
// tb_complex_arith_pipe: directed and randomized checks of complex_arith_pipe (W = 32).
module tb_complex_arith_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        ovf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [64:0] exp_q [$];   // {ovf, out} in acceptance order

  localparam logic signed [64:0] MAXV = 65'sd2147483647;
  localparam logic signed [64:0] MINV = -65'sd2147483648;

  complex_arith_pipe #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] reduce(input logic signed [64:0] x);
`ifdef COMPLEX_SAT_EN
    if (x > MAXV) return 32'h7FFFFFFF;
    if (x < MINV) return 32'h80000000;
`endif
    return x[31:0];
  endfunction

  // Reference: exact complex arithmetic in wide signed integers, then range reduction.
  function automatic logic [64:0] model(input logic [1:0] m_op, input logic [63:0] m_a, input logic [63:0] m_b);
    logic signed [31:0] ar32, ai32, br32, bi32;
    logic signed [64:0] ar, ai, br, bi, re, im;
    logic               o;
    ar32 = m_a[63:32]; ai32 = m_a[31:0];
    br32 = m_b[63:32]; bi32 = m_b[31:0];
    ar = ar32; ai = ai32; br = br32; bi = bi32;
    case (m_op)
      2'd0:    begin re = ar + br;           im = ai + bi;           end
      2'd1:    begin re = ar - br;           im = ai - bi;           end
      2'd2:    begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
      default: begin re = ar * br + ai * bi; im = ai * br - ar * bi; end
    endcase
    o = (re > MAXV) || (re < MINV) || (im > MAXV) || (im < MINV);
    return {o, reduce(re), reduce(im)};
  endfunction

  function automatic logic [31:0] rnd_comp();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and stall-hold monitor, sampled mid-cycle.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_out;
  logic        prev_ovf;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_out", out, prev_out);
        check("hold_ovf", 64'(ovf), 64'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("sb_out", out, e[63:0]);
          check("sb_ovf", 64'(ovf), 64'(e[64]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      prev_hold = out_valid && !out_ready;
      prev_out  = out;
      prev_ovf  = ovf;
    end
  end

  // One beat with no stall: result must appear exactly three edges after acceptance.
  task automatic run_vec(input string tag, input logic [1:0] v_op, input logic [63:0] v_a,
                         input logic [63:0] v_b, input logic [63:0] v_out, input logic v_ovf);
    op = v_op; a = v_a; b = v_b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_out"}, out, v_out);
    check({tag, "_ovf"}, 64'(ovf), 64'(v_ovf));
    $display("vec %s op=%0d a=%h b=%h out=%h ovf=%0b", tag, v_op, v_a, v_b, out, ovf);
  endtask

  initial begin
    int sent;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", out, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec("add", 2'd0, {32'd10, 32'd14}, {32'd8, 32'd9}, {32'd18, 32'd23}, 1'b0);
    run_vec("mul", 2'd2, {32'd1, 32'd2}, {32'd3, 32'd4}, {32'hFFFFFFFB, 32'd10}, 1'b0);
    run_vec("cmul", 2'd3, {32'd1, 32'd2}, {32'd3, 32'd4}, {32'd11, 32'd2}, 1'b0);
    run_vec("sub", 2'd1, {32'd1, 32'd2}, {32'd3, 32'd4}, {32'hFFFFFFFE, 32'hFFFFFFFE}, 1'b0);
`ifdef COMPLEX_SAT_EN
    run_vec("ovf_add", 2'd0, {32'h7FFFFFFF, 32'd0}, {32'd1, 32'd0}, {32'h7FFFFFFF, 32'd0}, 1'b1);
    run_vec("ovf_mul", 2'd2, {32'h80000000, 32'd0}, {32'h80000000, 32'd0}, {32'h7FFFFFFF, 32'd0}, 1'b1);
`else
    run_vec("ovf_add", 2'd0, {32'h7FFFFFFF, 32'd0}, {32'd1, 32'd0}, {32'h80000000, 32'd0}, 1'b1);
    run_vec("ovf_mul", 2'd2, {32'h80000000, 32'd0}, {32'h80000000, 32'd0}, {32'h00000000, 32'd0}, 1'b1);
`endif
    @(posedge clk); #1;

    // Backpressure: consumer stalled for 6 cycles while 5 beats are offered.
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 5); op = 2'd0; a = {32'(sent + 1), 32'd0}; b = '0;
      #1;
      if (in_ready && in_valid) sent++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(sent), 64'd4);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_first", out, {32'd1, 32'd0});
    out_ready = 1'b1; in_valid = 1'b1; a = {32'd5, 32'd0};
    #1;
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      check("bp_order_valid", 64'(out_valid), 64'd1);
      check("bp_order_out", out, {32'(i), 32'd0});
      $display("bp beat %0d out=%h", i, out);
      @(posedge clk); #1;
    end
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset mid-flight: two beats in flight are discarded.
    out_ready = 1'b1; in_valid = 1'b1; op = 2'd2; a = {32'd3, 32'd4}; b = {32'd5, 32'd6};
    @(posedge clk); #1;
    a = {32'd7, 32'd8};
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rst_flush_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_vec("post_rst", 2'd0, {32'd100, 32'd200}, {32'd1, 32'd2}, {32'd101, 32'd202}, 1'b0);

    // Randomized traffic with random backpressure, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = {rnd_comp(), rnd_comp()};
      b         = {rnd_comp(), rnd_comp()};
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
